// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: bit-reversed frame fill, FFT burst feed, windowed |re|+|im| peak pick
module fft_frame_ctrl #(
  parameter int DATLEN = 12,
  parameter int VLEN = 16,
  parameter int VLEN_LOG2 = 4,
  parameter int LO730 = 1,
  parameter int HI730 = 3,
  parameter int LO850 = 4,
  parameter int HI850 = 6,
  parameter int WAIT_MAX = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATLEN-1:0]   sample,
  input  logic                sample_valid,
  output logic [2*DATLEN-1:0] fft_in,
  output logic                fft_in_nd,
  input  logic [2*DATLEN-1:0] fft_out,
  input  logic                fft_out_nd,
  input  logic                fft_overflow,
  output logic [DATLEN-1:0]   max730,
  output logic [DATLEN-1:0]   max850,
  output logic                result_valid,
  output logic                overrun,
  output logic                fft_err
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  typedef enum logic [2:0] {FILL, FEED, WAIT, DRAIN, REPORT} state_t;
  state_t state, state_n;
  logic [DATLEN-1:0] mem [VLEN];
  logic [VLEN_LOG2-1:0] wr_cnt, wr_rev, rd_cnt, bin_cnt;
  logic [WW-1:0] wait_cnt;
  logic [DATLEN-1:0] run730, run850, re, im, mag;
  logic [DATLEN:0] abs_re, abs_im, sum;
  logic take, proc, timeout, last_bin, hit730, hit850;
  for (genvar i = 0; i < VLEN_LOG2; i++) begin : g_rev
    assign wr_rev[i] = wr_cnt[VLEN_LOG2-1-i];
  end
  assign take = sample_valid && state == FILL;
  assign proc = fft_out_nd && (state == WAIT || state == DRAIN);
  assign timeout = state == WAIT && !fft_out_nd && wait_cnt == WW'(WAIT_MAX - 1);
  assign last_bin = proc && bin_cnt == VLEN_LOG2'(VLEN - 1);
  assign {re, im} = fft_out;
  // one extra bit so |-2^(DATLEN-1)| is representable
  assign abs_re = re[DATLEN-1] ? {1'b0, ~re} + 1'b1 : {1'b0, re};
  assign abs_im = im[DATLEN-1] ? {1'b0, ~im} + 1'b1 : {1'b0, im};
  assign sum = abs_re + abs_im;
  assign mag = sum[DATLEN] ? '1 : sum[DATLEN-1:0];
  assign hit730 = bin_cnt >= VLEN_LOG2'(LO730) && bin_cnt <= VLEN_LOG2'(HI730);
  assign hit850 = bin_cnt >= VLEN_LOG2'(LO850) && bin_cnt <= VLEN_LOG2'(HI850);
  always_comb begin
    state_n = state;
    case (state)
      FILL:    if (take && wr_cnt == VLEN_LOG2'(VLEN - 1)) state_n = FEED;
      FEED:    if (rd_cnt == VLEN_LOG2'(VLEN - 1)) state_n = WAIT;
      WAIT:    state_n = fft_out_nd ? DRAIN : timeout ? FILL : WAIT;
      DRAIN:   if (last_bin) state_n = REPORT;
      default: state_n = FILL;
    endcase
  end
  always_ff @(posedge clk)
    if (take) mem[wr_rev] <= sample;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FILL;
      wr_cnt <= '0;
      rd_cnt <= '0;
      bin_cnt <= '0;
      wait_cnt <= '0;
      run730 <= '0;
      run850 <= '0;
      fft_in <= '0;
      fft_in_nd <= 1'b0;
      max730 <= '0;
      max850 <= '0;
      result_valid <= 1'b0;
      overrun <= 1'b0;
      fft_err <= 1'b0;
    end else begin
      state <= state_n;
      if (take) wr_cnt <= wr_cnt + 1'b1;
      rd_cnt <= state == FEED ? rd_cnt + 1'b1 : '0;
      fft_in_nd <= state == FEED;
      fft_in <= state == FEED ? {mem[rd_cnt], DATLEN'(0)} : '0;
      wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
      if (proc) bin_cnt <= bin_cnt + 1'b1;
      result_valid <= state == REPORT;
      if (state == REPORT) begin
        max730 <= run730;
        max850 <= run850;
        run730 <= '0;
        run850 <= '0;
      end else if (proc) begin
        if (hit730 && mag > run730) run730 <= mag;
        if (hit850 && mag > run850) run850 <= mag;
      end
      overrun <= overrun | (sample_valid && state != FILL);
      fft_err <= fft_err | fft_overflow | timeout;
    end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: scoreboard bench; stimulus queues expected feed words and maxima, a negedge monitor checks them
module tb_fft_frame_ctrl;
  localparam int D = 12;
  logic clk = 0, rst = 1;
  logic [D-1:0] sample = '0;
  logic sample_valid = 0;
  logic [2*D-1:0] fft_in;
  logic fft_in_nd;
  logic [2*D-1:0] fft_out = '0;
  logic fft_out_nd = 0, fft_overflow = 0;
  logic [D-1:0] max730, max850;
  logic result_valid, overrun, fft_err;

  fft_frame_ctrl dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .fft_in(fft_in), .fft_in_nd(fft_in_nd), .fft_out(fft_out), .fft_out_nd(fft_out_nd),
    .fft_overflow(fft_overflow), .max730(max730), .max850(max850),
    .result_valid(result_valid), .overrun(overrun), .fft_err(fft_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [D-1:0] a; logic [D-1:0] b;} res_t;
  logic [D-1:0] in_q[$];
  res_t res_q[$];
  int checks = 0, errors = 0;
  int run = 0, nd_seen = 0, rv_seen = 0;
  int br[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int wr[16], wi[16], sr[16], si[16], zr[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [D-1:0] e;
    res_t r;
    if (rst) run = 0;
    else begin
      if (fft_in_nd) begin
        nd_seen++;
        run++;
        if (in_q.size() == 0) chk("unexpected_fft_in", 1, 0);
        else begin
          e = in_q.pop_front();
          chk("fft_in_re", int'(fft_in[2*D-1:D]), int'(e));
          chk("fft_in_im", int'(fft_in[D-1:0]), 0);
        end
      end else if (run != 0) begin
        chk("feed_burst_len", run, 16);
        run = 0;
      end
      if (result_valid) begin
        rv_seen++;
        if (res_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          r = res_q.pop_front();
          chk("max730", int'(max730), int'(r.a));
          chk("max850", int'(max850), int'(r.b));
        end
      end
    end
  end

  task automatic send(input int base, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      sample = D'(base + i);
      sample_valid = 1;
      @(posedge clk); #1;
    end
    sample_valid = 0;
  endtask

  task automatic push_feed(input int base);
    for (int k = 0; k < 16; k++) in_q.push_back(D'(base + br[k]));
  endtask

  task automatic wait_feed();
    int t = 0;
    while (!fft_in_nd && t < 100) begin @(negedge clk); t++; end
    chk("feed_start", int'(fft_in_nd), 1);
    while (fft_in_nd && t < 100) begin @(negedge clk); t++; end
    chk("feed_end", int'(fft_in_nd), 0);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int re[16], input int im[16], input int a, input int b,
                       input int gap, input int ovf);
    int t = 0;
    res_q.push_back('{D'(a), D'(b)});
    for (int k = 0; k < 16; k++) begin
      fft_out = {D'(re[k]), D'(im[k])};
      fft_out_nd = 1;
      fft_overflow = (k == ovf);
      @(posedge clk); #1;
      fft_out_nd = 0;
      fft_overflow = 0;
      if (gap != 0) begin @(posedge clk); #1; end
    end
    while (res_q.size() != 0 && t < 10) begin @(posedge clk); #1; t++; end
    chk("result_arrived", res_q.size(), 0);
    res_q.delete();
  endtask

  initial begin
    int c, t, n0;
    foreach (wr[i]) begin wr[i] = 0; wi[i] = 0; sr[i] = 0; si[i] = 0; zr[i] = 0; end
    wr[2] = 100;   wi[2] = -50;
    wr[3] = -120;  wi[3] = 10;
    wr[5] = 7;     wi[5] = 7;
    wr[9] = 2000;  wi[9] = 0;
    sr[1] = -2048; si[1] = -2048;
    repeat (2) @(posedge clk); #1;
    chk("rst_fft_in", int'(fft_in), 0);
    chk("rst_fft_in_nd", int'(fft_in_nd), 0);
    chk("rst_max730", int'(max730), 0);
    chk("rst_max850", int'(max850), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_fft_err", int'(fft_err), 0);
    rst = 0;
    @(posedge clk); #1;
    // reset during the feed burst
    push_feed(0);
    send(0, 0, 16);
    c = 0; t = 0;
    while (c < 5 && t < 50) begin @(negedge clk); if (fft_in_nd) c++; t++; end
    chk("fifth_nd_seen", c, 5);
    #1 rst = 1;
    #1;
    chk("async_rst_nd", int'(fft_in_nd), 0);
    chk("async_rst_fft_in", int'(fft_in), 0);
    in_q.delete();
    repeat (2) @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    send(0, 0, 15);
    n0 = nd_seen;
    repeat (20) @(posedge clk); #1;
    chk("no_feed_before_16", nd_seen - n0, 0);
    push_feed(0);
    send(0, 15, 1);
    wait_feed();
    drain(wr, wi, 150, 14, 0, -1);
    push_feed(100);
    send(100, 0, 16);
    wait_feed();
    drain(sr, si, 4095, 0, 1, -1);
    push_feed(200);
    send(200, 0, 16);
    wait_feed();
    drain(zr, zr, 0, 0, 0, -1);
    // timeout with no core output
    chk("err_before_timeout", int'(fft_err), 0);
    push_feed(300);
    send(300, 0, 16);
    wait_feed();
    n0 = rv_seen;
    repeat (249) @(negedge clk);
    chk("err_not_early", int'(fft_err), 0);
    t = 0;
    while (!fft_err && t < 20) begin @(negedge clk); t++; end
    chk("timeout_err", int'(fft_err), 1);
    repeat (5) @(negedge clk);
    chk("timeout_no_result", rv_seen - n0, 0);
    @(posedge clk); #1;
    push_feed(400);
    send(400, 0, 16);
    wait_feed();
    drain(wr, wi, 150, 14, 0, -1);
    // overrun during FEED, overflow during DRAIN
    rst = 1;
    repeat (2) @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("rst_clears_err", int'(fft_err), 0);
    chk("rst_clears_overrun", int'(overrun), 0);
    push_feed(500);
    send(500, 0, 16);
    t = 0;
    while (!fft_in_nd && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    sample = 12'd7;
    sample_valid = 1;
    @(posedge clk); #1;
    sample_valid = 0;
    wait_feed();
    drain(wr, wi, 150, 14, 1, 5);
    chk("overrun_sticky", int'(overrun), 1);
    chk("overflow_err", int'(fft_err), 1);
    push_feed(600);
    send(600, 0, 16);
    wait_feed();
    drain(sr, si, 4095, 0, 0, -1);
    chk("queue_empty", in_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
